// File: rtl/rob_pkg.sv
// Shared types and default sizes for the circular reorder buffer.
package rob_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_WIDTH  = 2;
  localparam int ROB_PREG_W = 6;
  localparam int ROB_PC_W   = 32;

  typedef struct packed {
    logic                  v;
    logic                  done;
    logic [ROB_PREG_W-1:0] dest_reg;
    logic [ROB_PREG_W-1:0] old_dest_reg;
    logic [ROB_PC_W-1:0]   pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_ring_if.sv
// Dispatch, completion and commit bundle of the reorder buffer; slave is the ROB side.
interface rob_ring_if
  import rob_pkg::*;
#(
  parameter int DEPTH      = ROB_DEPTH,
  parameter int WIDTH      = ROB_WIDTH,
  parameter int CMPL_PORTS = 3,
  parameter int PREG_W     = ROB_PREG_W,
  parameter int PC_W       = ROB_PC_W
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0]            disp_valid;
  logic [WIDTH*PREG_W-1:0]     disp_dest_reg;
  logic [WIDTH*PREG_W-1:0]     disp_old_dest_reg;
  logic [WIDTH*PC_W-1:0]       disp_pc;
  logic                        disp_ready;
  logic [WIDTH*IDX_W-1:0]      disp_rob_idx;
  logic [CMPL_PORTS-1:0]       cmpl_valid;
  logic [CMPL_PORTS*IDX_W-1:0] cmpl_rob_idx;
  logic [WIDTH-1:0]            commit_valid;
  logic [WIDTH*PREG_W-1:0]     commit_dest_reg;
  logic [WIDTH*PREG_W-1:0]     commit_old_dest_reg;
  logic [WIDTH*PC_W-1:0]       commit_pc;
  logic [IDX_W:0]              rob_count;
  logic                        rob_empty;

  modport master (
    output disp_valid, disp_dest_reg, disp_old_dest_reg, disp_pc,
    output cmpl_valid, cmpl_rob_idx,
    input  disp_ready, disp_rob_idx,
    input  commit_valid, commit_dest_reg, commit_old_dest_reg, commit_pc,
    input  rob_count, rob_empty
  );

  modport slave (
    input  disp_valid, disp_dest_reg, disp_old_dest_reg, disp_pc,
    input  cmpl_valid, cmpl_rob_idx,
    output disp_ready, disp_rob_idx,
    output commit_valid, commit_dest_reg, commit_old_dest_reg, commit_pc,
    output rob_count, rob_empty
  );

endinterface

// File: rtl/rob_commit_sel.sv
// In-order commit lane selection: a lane retires only if it and every lane below it is valid and done.
module rob_commit_sel #(
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] rel_v,
  input  logic [WIDTH-1:0] rel_done,
  output logic [WIDTH-1:0] commit_valid,
  output logic [CNT_W-1:0] commit_cnt
);

  logic run;

  // NOTE: every always_comb output gets a default before any conditional logic, so no latch can be inferred.
  always_comb begin
    run          = 1'b1;
    commit_valid = '0;
    commit_cnt   = '0;
    for (int j = 0; j < WIDTH; j++) begin
      run             = run & rel_v[j] & rel_done[j];
      commit_valid[j] = run;
      commit_cnt      = commit_cnt + CNT_W'(run);
    end
  end

endmodule

// File: rtl/rob_ring.sv
// Circular reorder buffer: WIDTH-wide in-order allocate and retire, out-of-order completion.
// Optional synchronous flush port is built when ROB_FLUSH_EN is defined.
module rob_ring
  import rob_pkg::*;
#(
  parameter int DEPTH      = ROB_DEPTH,
  parameter int WIDTH      = ROB_WIDTH,
  parameter int CMPL_PORTS = 3,
  parameter int PREG_W     = ROB_PREG_W,
  parameter int PC_W       = ROB_PC_W
) (
  input  logic      clk,
  input  logic      rst_n,
`ifdef ROB_FLUSH_EN
  input  logic      flush,
`endif
  rob_ring_if.slave bus
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int LCNT_W = $clog2(WIDTH + 1);

  rob_entry_t       rob_q [DEPTH];
  rob_entry_t       rob_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic              disp_ready;
  logic [IDX_W-1:0]  disp_idx [WIDTH];
  logic [LCNT_W-1:0] lane_off;
  logic [LCNT_W-1:0] alloc_cnt;

  logic [IDX_W-1:0]  rel_idx [WIDTH];
  logic [WIDTH-1:0]  rel_v, rel_done;
  logic [WIDTH-1:0]  sel_valid, commit_valid;
  logic [LCNT_W-1:0] sel_cnt, commit_cnt;

  logic [WIDTH*PREG_W-1:0] commit_dest, commit_old;
  logic [WIDTH*PC_W-1:0]   commit_pc;
  logic [WIDTH*IDX_W-1:0]  disp_rob_idx;

  // Fullness comes only from count; a slot freed by this cycle's commit is not reusable yet.
  assign disp_ready = (count_q <= CNT_W'(DEPTH - WIDTH));

  // Valid lanes are packed onto consecutive slots starting at tail.
  always_comb begin
    lane_off     = '0;
    disp_rob_idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      disp_idx[k] = tail_q + IDX_W'(lane_off);
      disp_rob_idx[k*IDX_W +: IDX_W] = disp_idx[k];
      if (bus.disp_valid[k]) lane_off = lane_off + LCNT_W'(1);
    end
    alloc_cnt = disp_ready ? lane_off : '0;
  end

  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      rel_idx[j]  = head_q + IDX_W'(j);
      rel_v[j]    = rob_q[rel_idx[j]].v;
      rel_done[j] = rob_q[rel_idx[j]].done;
    end
  end

  rob_commit_sel #(
    .WIDTH (WIDTH),
    .CNT_W (LCNT_W)
  ) u_commit_sel (
    .rel_v        (rel_v),
    .rel_done     (rel_done),
    .commit_valid (sel_valid),
    .commit_cnt   (sel_cnt)
  );

  always_comb begin
    commit_valid = sel_valid;
    commit_cnt   = sel_cnt;
`ifdef ROB_FLUSH_EN
    if (flush) begin
      commit_valid = '0;
      commit_cnt   = '0;
    end
`endif
    commit_dest = '0;
    commit_old  = '0;
    commit_pc   = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (commit_valid[j]) begin
        commit_dest[j*PREG_W +: PREG_W] = rob_q[rel_idx[j]].dest_reg;
        commit_old[j*PREG_W +: PREG_W]  = rob_q[rel_idx[j]].old_dest_reg;
        commit_pc[j*PC_W +: PC_W]       = rob_q[rel_idx[j]].pc;
      end
    end
  end

  // Allocation targets only free slots and commit only occupied ones, so their writes never collide.
  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q + IDX_W'(commit_cnt);
    tail_d  = tail_q + IDX_W'(alloc_cnt);
    count_d = count_q + CNT_W'(alloc_cnt) - CNT_W'(commit_cnt);

    for (int p = 0; p < CMPL_PORTS; p++) begin
      if (bus.cmpl_valid[p] && rob_q[bus.cmpl_rob_idx[p*IDX_W +: IDX_W]].v)
        rob_d[bus.cmpl_rob_idx[p*IDX_W +: IDX_W]].done = 1'b1;
    end

    for (int j = 0; j < WIDTH; j++) begin
      if (commit_valid[j]) begin
        rob_d[rel_idx[j]].v    = 1'b0;
        rob_d[rel_idx[j]].done = 1'b0;
      end
    end

    if (disp_ready) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (bus.disp_valid[k]) begin
          rob_d[disp_idx[k]] = '{v:            1'b1,
                                 done:         1'b0,
                                 dest_reg:     bus.disp_dest_reg[k*PREG_W +: PREG_W],
                                 old_dest_reg: bus.disp_old_dest_reg[k*PREG_W +: PREG_W],
                                 pc:           bus.disp_pc[k*PC_W +: PC_W]};
        end
      end
    end

`ifdef ROB_FLUSH_EN
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_d[i].v    = 1'b0;
        rob_d[i].done = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
`endif
  end

  // NOTE: the whole entry array is reset, not just v/done; the buffer is small and this keeps every flop's reset behaviour uniform.
  // NOTE: sequential state is updated only with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign bus.disp_ready          = disp_ready;
  assign bus.disp_rob_idx        = disp_rob_idx;
  assign bus.commit_valid        = commit_valid;
  assign bus.commit_dest_reg     = commit_dest;
  assign bus.commit_old_dest_reg = commit_old;
  assign bus.commit_pc           = commit_pc;
  assign bus.rob_count           = count_q;
  assign bus.rob_empty           = (count_q == '0);

endmodule
